// File: rtl/fir_sample_sequencer.sv
// Front-end sequencer for the 4-tap FIR: shifts accepted samples into the tap
// delay line, kicks the FIR, and returns its result on a valid/ready stream.
module fir_sample_sequencer #(
   parameter int DATA_W   = 8,
   parameter int RES_W    = 18,
   parameter int TAPS     = 4,
   parameter int CALC_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              flush,
   output logic [DATA_W-1:0] x0,
   output logic [DATA_W-1:0] x1,
   output logic [DATA_W-1:0] x2,
   output logic [DATA_W-1:0] x3,
   output logic              fir_enable,
   input  logic [RES_W-1:0]  fir_result,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [RES_W-1:0]  m_data,
   output logic              primed,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [3:0] LAT_C  = 4'(CALC_LAT);
   localparam logic [2:0] TAPS_C = 3'(TAPS);

   state_t     state;
   state_t     state_next;
   logic [2:0] fill_cnt;
   logic [2:0] fill_inc;
   logic [3:0] calc_cnt;
   logic       accept;
   logic       calc_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Samples are only taken in IDLE, so the taps stay frozen while the FIR
   // computes and while a result waits for the downstream.
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      calc_done  = 1'b0;
      case (state)
         IDLE: begin
            s_ready = ~flush;
            if (s_valid && !flush) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (calc_cnt == LAT_C) begin
               calc_done  = 1'b1;
               state_next = OUT;
            end
         end
         OUT: begin
            if (m_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   assign accept   = s_valid & s_ready;
   assign fill_inc = (fill_cnt == TAPS_C) ? fill_cnt : 3'(fill_cnt + 3'd1);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0       <= '0;
         x1       <= '0;
         x2       <= '0;
         x3       <= '0;
         fill_cnt <= '0;
         primed   <= 1'b0;
      end else if (flush) begin
         x0       <= '0;
         x1       <= '0;
         x2       <= '0;
         x3       <= '0;
         fill_cnt <= '0;
         primed   <= 1'b0;
      end else if (accept) begin
         x3       <= x2;
         x2       <= x1;
         x1       <= x0;
         x0       <= s_data;
         fill_cnt <= fill_inc;
         primed   <= (fill_inc == TAPS_C);
      end
   end

   // fir_enable is high only in the cycle right after the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fir_enable <= 1'b0;
         calc_cnt   <= '0;
      end else if (flush) begin
         fir_enable <= 1'b0;
         calc_cnt   <= '0;
      end else begin
         fir_enable <= accept;
         if (accept) begin
            calc_cnt <= 4'd1;
         end else if (state == CALC) begin
            calc_cnt <= calc_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
      end else if (calc_done) begin
         m_valid <= 1'b1;
         m_data  <= fir_result;
      end else if (state == OUT && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule
